// File: rtl/vga_pkg.sv
// Shared timing defaults, FSM state encoding and counter types for the VGA decoder.
package vga_pkg;
  localparam int CNT_W            = 11;
  localparam int RGB_W            = 12;
  localparam int GF_W             = 8;
  localparam int H_TOTAL_DEF      = 1056;
  localparam int V_TOTAL_DEF      = 628;
  localparam int H_ACTIVE_DEF     = 800;
  localparam int V_ACTIVE_DEF     = 600;
  localparam int H_SYNC_START_DEF = 840;
  localparam int V_SYNC_START_DEF = 601;
  localparam int LOCK_FRAMES_DEF  = 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;
  typedef enum logic [1:0] { SEARCH, ALIGN, LOCKED } vga_state_e;

  function automatic cnt_t wrap_inc(cnt_t val, cnt_t last);
    return (val == last) ? '0 : val + cnt_t'(1);
  endfunction
endpackage

// File: rtl/vga_decoder_if.sv
// Raw sync/pixel stream into the decoder and recovered timing out of it.
interface vga_decoder_if;
  import vga_pkg::*;

  logic hs;
  logic vs;
  rgb_t rgb;
  cnt_t hcount;
  cnt_t vcount;
  logic de;
  rgb_t rgb_out;
  logic frame_start;
  logic locked;
  logic sync_err;

  modport master (
    output hs, vs, rgb,
    input  hcount, vcount, de, rgb_out, frame_start, locked, sync_err
  );

  modport slave (
    input  hs, vs, rgb,
    output hcount, vcount, de, rgb_out, frame_start, locked, sync_err
  );
endinterface

// File: rtl/vga_edge_det.sv
// Registers the incoming sync/pixel pins once and flags hs/vs rising edges
// between consecutive registered samples.
module vga_edge_det
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hs_i,
  input  logic vs_i,
  input  rgb_t rgb_i,
  output logic hs_rise_o,
  output logic vs_rise_o,
  output rgb_t rgb_o
);
  logic hs_q, hs_prev_q, vs_q, vs_prev_q;
  rgb_t rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs_i;
      hs_prev_q <= hs_q;
      vs_q      <= vs_i;
      vs_prev_q <= vs_q;
      rgb_q     <= rgb_i;
    end
  end

  assign hs_rise_o = hs_q & ~hs_prev_q;
  assign vs_rise_o = vs_q & ~vs_prev_q;
  assign rgb_o     = rgb_q;
endmodule

// File: rtl/vga_decoder.sv
// VGA timing recovery: aligns pixel/line counters to incoming hs/vs edges and
// qualifies the pixel stream once the timing has been stable for a few frames.
//
// state  | meaning
// SEARCH | counters free-run; waiting for an hs edge followed by a vs edge
// ALIGN  | counters aligned; counting consecutive clean frames
// LOCKED | timing trusted; de and frame_start enabled
module vga_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
  input logic          clk,
  input logic          rst,
  vga_decoder_if.slave vga
);
  localparam cnt_t            H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t            V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t            H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t            V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t            H_SS    = cnt_t'(H_SYNC_START);
  localparam cnt_t            V_SS    = cnt_t'(V_SYNC_START);
  localparam logic [GF_W-1:0] GF_LOCK = GF_W'(LOCK_FRAMES);

  logic hs_rise, vs_rise;
  rgb_t rgb_s;

  vga_edge_det u_edge (
    .clk      (clk),
    .rst_n    (rst),
    .hs_i     (vga.hs),
    .vs_i     (vga.vs),
    .rgb_i    (vga.rgb),
    .hs_rise_o(hs_rise),
    .vs_rise_o(vs_rise),
    .rgb_o    (rgb_s)
  );

  vga_state_e      state_q, state_d;
  cnt_t            hcount_q, hcount_d, vcount_q, vcount_d;
  logic [GF_W-1:0] gf_q, gf_d;
  logic            h_seen_q, h_seen_d;
  logic            h_resync_q, h_resync_d, v_resync_q, v_resync_d;
  logic            err_seen_q, err_seen_d;
  logic            sync_err_q, sync_err_d;
  rgb_t            rgb_px_q;

  cnt_t h_free, v_free, h_ld;
  logic hs_miss, hs_bad, vs_miss, vs_bad, err;

  assign h_free  = wrap_inc(hcount_q, H_LAST);
  assign v_free  = (hcount_q == H_LAST) ? wrap_inc(vcount_q, V_LAST) : vcount_q;
  assign h_ld    = hs_rise ? H_SS : h_free;
  // After a missing edge, the next edge is taken as the new reference instead
  // of being flagged a second time, so a slipped line costs a single error.
  assign hs_miss = !hs_rise && (h_free == H_SS);
  assign hs_bad  = hs_rise && (h_free != H_SS) && !h_resync_q;
  assign vs_miss = !vs_rise && (h_free == '0) && (v_free == V_SS);
  assign vs_bad  = vs_rise && (((v_free != V_SS) && !v_resync_q) || (h_ld != '0));
  assign err     = hs_miss | hs_bad | vs_miss | vs_bad;

  always_comb begin
    state_d    = state_q;
    hcount_d   = h_ld;
    vcount_d   = v_free;
    gf_d       = gf_q;
    h_seen_d   = h_seen_q;
    h_resync_d = h_resync_q & ~hs_rise;
    v_resync_d = v_resync_q & ~vs_rise;
    err_seen_d = err_seen_q;
    sync_err_d = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (hs_rise) h_seen_d = 1'b1;
        if (vs_rise && h_seen_q) begin
          vcount_d   = V_SS;
          state_d    = ALIGN;
          gf_d       = '0;
          err_seen_d = 1'b0;
          h_resync_d = 1'b0;
          v_resync_d = 1'b0;
        end
      end
      default: begin
        if (vs_rise) vcount_d = V_SS;
        if (err) begin
          state_d    = ALIGN;
          sync_err_d = 1'b1;
          gf_d       = '0;
          err_seen_d = 1'b1;
          if (hs_miss) h_resync_d = 1'b1;
          if (vs_miss) v_resync_d = 1'b1;
        end else if (vs_rise) begin
          err_seen_d = 1'b0;
          if (state_q == ALIGN && !err_seen_q) begin
            gf_d = gf_q + GF_W'(1);
            if (gf_q + GF_W'(1) >= GF_LOCK) state_d = LOCKED;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEARCH;
      hcount_q   <= '0;
      vcount_q   <= '0;
      gf_q       <= '0;
      h_seen_q   <= 1'b0;
      h_resync_q <= 1'b0;
      v_resync_q <= 1'b0;
      err_seen_q <= 1'b0;
      sync_err_q <= 1'b0;
      rgb_px_q   <= '0;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      gf_q       <= gf_d;
      h_seen_q   <= h_seen_d;
      h_resync_q <= h_resync_d;
      v_resync_q <= v_resync_d;
      err_seen_q <= err_seen_d;
      sync_err_q <= sync_err_d;
      rgb_px_q   <= rgb_s;
    end
  end

  logic locked_s, de_s;
  assign locked_s        = (state_q == LOCKED);
  assign de_s            = locked_s && (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.locked      = locked_s;
  assign vga.de          = de_s;
  assign vga.rgb_out     = de_s ? rgb_px_q : '0;
  assign vga.frame_start = locked_s && (hcount_q == '0) && (vcount_q == '0);
  assign vga.sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_decoder.sv
// Directed bench for vga_decoder using a scaled-down raster so several frames
// fit in a short run; the bench's own raster generator supplies expectations.
module tb_vga_decoder;
  localparam int HT = 40, VT = 20, HA = 24, VA = 12, HSS = 30, VSS = 13, LF = 2;
  localparam int FRAME = HT * VT;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    int          vsn;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   gh = 0, gv = 0, stall_n = 0, vs_n = 0;
  bit   hs_hold_low = 0;
  bit   rgb_ovr_en = 0;
  logic [11:0] rgb_ovr = '0;
  px_t  last_px = '{h: 0, v: 0, rgb: 12'h000, vsn: 0};
  px_t  obs     = '{h: 0, v: 0, rgb: 12'h000, vsn: 0};

  vga_decoder_if vga ();

  vga_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HSS), .V_SYNC_START(VSS), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  // Drive one raster pixel; afterwards 'obs' is the pixel the outputs now show.
  task automatic tick();
    px_t cur;
    bit  stall;
    stall   = (stall_n > 0);
    cur.h   = gh;
    cur.v   = gv;
    cur.rgb = rgb_ovr_en ? rgb_ovr : 12'(gh * 37 + gv * 101 + 1);
    rgb_ovr_en = 0;
    if (!stall && gh == 0 && gv == VSS) vs_n++;
    cur.vsn = vs_n;
    vga.hs  = !stall && !hs_hold_low && gh >= HSS && gh < HSS + 4;
    vga.vs  = (gv == VSS) || (gv == VSS + 1);
    vga.rgb = cur.rgb;
    @(posedge clk);
    #1;
    obs     = last_px;
    last_px = cur;
    if (stall) stall_n--;
    else begin
      gh = (gh == HT - 1) ? 0 : gh + 1;
      if (gh == 0) gv = (gv == VT - 1) ? 0 : gv + 1;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v && stall_n == 0) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++; errors++;
      $display("FAIL run_to timeout target=(%0d,%0d) at=(%0d,%0d)", h, v, gh, gv);
    end
  endtask

  task automatic test_reset();
    vga.hs = 0; vga.vs = 0; vga.rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vga.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount got=%0d want=0", vga.hcount); end
    checks++; if (vga.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount got=%0d want=0", vga.vcount); end
    checks++; if (vga.de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b want=0", vga.de); end
    checks++; if (vga.rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb_out got=%h want=000", vga.rgb_out); end
    checks++; if (vga.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", vga.locked); end
    checks++; if (vga.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b want=0", vga.frame_start); end
    checks++; if (vga.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got=%b want=0", vga.sync_err); end
    rst = 1'b1;
    gh = 0; gv = 0; vs_n = 0;
  endtask

  task automatic test_lock();
    int  pulses = 0;
    bit  exp_l;
    for (int i = 0; i < 3 * FRAME + 50; i++) begin
      tick();
      if (vga.sync_err === 1'b1) pulses++;
      exp_l = (obs.vsn >= 3);
      checks++;
      if (vga.locked !== exp_l) begin errors++; $display("FAIL lock_state px=(%0d,%0d) got=%b want=%b", obs.h, obs.v, vga.locked, exp_l); end
      if (exp_l) begin
        checks++;
        if (vga.hcount !== 11'(obs.h) || vga.vcount !== 11'(obs.v)) begin
          errors++; $display("FAIL lock_pos got=(%0d,%0d) want=(%0d,%0d)", vga.hcount, vga.vcount, obs.h, obs.v);
        end
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL lock_sync_err pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_frame_start();
    run_to(0, 0);
    rgb_ovr = 12'hF00; rgb_ovr_en = 1;
    tick();
    tick();
    checks++; if (vga.hcount !== 11'd0 || vga.vcount !== 11'd0) begin errors++; $display("FAIL fs_pos got=(%0d,%0d) want=(0,0)", vga.hcount, vga.vcount); end
    checks++; if (vga.de !== 1'b1) begin errors++; $display("FAIL fs_de got=%b want=1", vga.de); end
    checks++; if (vga.rgb_out !== 12'hF00) begin errors++; $display("FAIL fs_rgb got=%h want=F00", vga.rgb_out); end
    checks++; if (vga.frame_start !== 1'b1) begin errors++; $display("FAIL fs_pulse got=%b want=1", vga.frame_start); end
    tick();
    checks++; if (vga.frame_start !== 1'b0) begin errors++; $display("FAIL fs_width got=%b want=0 at (1,0)", vga.frame_start); end
  endtask

  task automatic test_blanking();
    int          bh[5]   = '{32, 23, 24, 0, 10};
    int          bv[5]   = '{5, 11, 11, 12, 15};
    logic [11:0] brgb[5] = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'hDEF};
    bit          bde[5]  = '{0, 1, 0, 0, 0};
    logic [11:0] exp_rgb;
    for (int i = 0; i < 5; i++) begin
      run_to(bh[i], bv[i]);
      rgb_ovr = brgb[i]; rgb_ovr_en = 1;
      tick();
      tick();
      exp_rgb = bde[i] ? brgb[i] : 12'h000;
      checks++; if (vga.hcount !== 11'(bh[i]) || vga.vcount !== 11'(bv[i])) begin errors++; $display("FAIL blank_pos got=(%0d,%0d) want=(%0d,%0d)", vga.hcount, vga.vcount, bh[i], bv[i]); end
      checks++; if (vga.de !== bde[i]) begin errors++; $display("FAIL blank_de px=(%0d,%0d) got=%b want=%b", bh[i], bv[i], vga.de, bde[i]); end
      checks++; if (vga.rgb_out !== exp_rgb) begin errors++; $display("FAIL blank_rgb px=(%0d,%0d) got=%h want=%h", bh[i], bv[i], vga.rgb_out, exp_rgb); end
    end
  endtask

  task automatic test_hs_delay();
    int pulses = 0;
    int base;
    bit exp_l;
    run_to(HSS, 3);
    stall_n = 3;
    base = vs_n;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (vga.sync_err === 1'b1) pulses++;
      if (i == 1) begin
        checks++; if (vga.sync_err !== 1'b1) begin errors++; $display("FAIL delay_err got=%b want=1", vga.sync_err); end
        checks++; if (vga.hcount !== 11'(HSS)) begin errors++; $display("FAIL delay_err_pos got=%0d want=%0d", vga.hcount, HSS); end
      end
      if (i == 4) begin
        checks++; if (vga.hcount !== 11'(HSS) || vga.sync_err !== 1'b0) begin errors++; $display("FAIL delay_reload hcount=%0d err=%b want=%0d/0", vga.hcount, vga.sync_err, HSS); end
      end
      if (i >= 1) begin
        exp_l = (obs.vsn - base >= 3);
        checks++;
        if (vga.locked !== exp_l) begin errors++; $display("FAIL delay_lock px=(%0d,%0d) got=%b want=%b", obs.h, obs.v, vga.locked, exp_l); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL delay_pulses got=%0d want=1", pulses); end
    checks++; if (vga.locked !== 1'b1) begin errors++; $display("FAIL delay_relock got=%b want=1", vga.locked); end
  endtask

  task automatic test_hs_stuck();
    bit seen = 0;
    int n = 0;
    run_to(0, 4);
    hs_hold_low = 1;
    for (int i = 0; i < 2 * HT && !seen; i++) begin
      tick();
      if (vga.sync_err === 1'b1) begin
        seen = 1;
        checks++; if (vga.hcount !== 11'(HSS) || vga.vcount !== 11'd4) begin errors++; $display("FAIL stuck_pos got=(%0d,%0d) want=(%0d,4)", vga.hcount, vga.vcount, HSS); end
        checks++; if (vga.locked !== 1'b0) begin errors++; $display("FAIL stuck_locked got=%b want=0", vga.locked); end
      end
    end
    hs_hold_low = 0;
    checks++; if (!seen) begin errors++; $display("FAIL stuck_no_err got=0 want=1 within %0d cycles", 2 * HT); end
    while (vga.locked !== 1'b1 && n < 4 * FRAME) begin tick(); n++; end
    checks++; if (vga.locked !== 1'b1) begin errors++; $display("FAIL stuck_relock got=%b want=1", vga.locked); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit exp_l;
    run_to(5, 7);
    tick();
    tick();
    checks++; if (vga.locked !== 1'b1) begin errors++; $display("FAIL rmid_pre_locked got=%b want=1", vga.locked); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (vga.hcount !== 11'd0 || vga.vcount !== 11'd0) begin errors++; $display("FAIL rmid_pos got=(%0d,%0d) want=(0,0)", vga.hcount, vga.vcount); end
    checks++; if (vga.de !== 1'b0 || vga.rgb_out !== 12'h000) begin errors++; $display("FAIL rmid_pix de=%b rgb=%h want=0/000", vga.de, vga.rgb_out); end
    checks++; if (vga.locked !== 1'b0 || vga.frame_start !== 1'b0 || vga.sync_err !== 1'b0) begin errors++; $display("FAIL rmid_flags locked=%b fs=%b err=%b want=0", vga.locked, vga.frame_start, vga.sync_err); end
    repeat (3) tick();
    rst = 1'b1;
    base = vs_n;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      exp_l = (obs.vsn - base >= 3);
      checks++;
      if (vga.locked !== exp_l) begin errors++; $display("FAIL rmid_lock px=(%0d,%0d) got=%b want=%b", obs.h, obs.v, vga.locked, exp_l); end
    end
    checks++; if (vga.locked !== 1'b1) begin errors++; $display("FAIL rmid_relock got=%b want=1", vga.locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame_start();
    test_blanking();
    test_hs_delay();
    test_hs_stuck();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_decoder.md
VGA_DECODER -- requirements
Module: vga_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1056, clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 628, lines per frame.
REQ-003 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-005 SHALL have parameter H_SYNC_START, default 840, hcount at which hs rises.
REQ-006 SHALL have parameter V_SYNC_START, default 601, vcount at which vs rises (at hcount 0).
REQ-007 SHALL have parameter LOCK_FRAMES, default 2, consecutive error-free frames required to lock.
REQ-008 port clk  input  1  pixel clock, one pixel per cycle.
REQ-009 port rst  input  1  reset; asynchronous, active-low.
REQ-010 port hs  input  1  horizontal sync, active-high.
REQ-011 port vs  input  1  vertical sync, active-high.
REQ-012 port rgb  input  12  pixel {r,g,b}, 4 bits each.
REQ-013 port hcount  output  11  recovered pixel column.
REQ-014 port vcount  output  11  recovered line.
REQ-015 port de  output  1  recovered active-video flag.
REQ-016 port rgb_out  output  12  pixel aligned with hcount/vcount/de.
REQ-017 port frame_start  output  1  one-cycle pulse at pixel (0,0) while locked.
REQ-018 port locked  output  1  timing lock status.
REQ-019 port sync_err  output  1  one-cycle pulse on any sync mismatch.

Function
REQ-020 hs, vs and rgb SHALL be registered once; rising edges SHALL be detected between consecutive registered samples.
REQ-021 hcount SHALL increment each cycle and wrap from H_TOTAL-1 to 0; on wrap vcount SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-022 The sample carrying an hs rising edge SHALL be assigned hcount = H_SYNC_START; the sample carrying a vs rising edge SHALL be assigned vcount = V_SYNC_START.
REQ-023 FSM states: SEARCH, ALIGN, LOCKED.
REQ-024 SEARCH: counters free-run; the first hs edge SHALL load hcount; the first subsequent vs edge SHALL load vcount and move to ALIGN.
REQ-025 ALIGN: the good-frame counter SHALL increment at each vs edge with no error since the previous vs edge; on reaching LOCK_FRAMES the FSM SHALL enter LOCKED.
REQ-026 Error: hs edge with free-running hcount != H_SYNC_START, hcount reaching H_SYNC_START without an hs edge, or vs edge with vcount != V_SYNC_START or hcount != 0.
REQ-027 On error in ALIGN or LOCKED: sync_err SHALL pulse one cycle, the good-frame counter SHALL clear, counters SHALL reload from the offending edge, and the state SHALL become ALIGN; in SEARCH, errors SHALL be ignored.
REQ-028 Simultaneous hs and vs edges SHALL load both counters in the same cycle; the vs check SHALL then flag an error (hcount != 0).
REQ-029 locked SHALL be 1 only in LOCKED.
REQ-030 de SHALL equal locked AND hcount < H_ACTIVE AND vcount < V_ACTIVE; rgb_out SHALL equal the registered rgb when de = 1, else 0.
REQ-031 Latency from input pins to hcount/vcount/de/rgb_out SHALL be exactly 2 clk cycles.
REQ-032 hs or vs stuck at either level SHALL produce an error at the next expected edge position.

Reset
REQ-033 With rst low: state SEARCH; hcount, vcount, rgb_out = 0; de, frame_start, locked, sync_err = 0; good-frame counter and edge-detector history = 0.
REQ-034 Reset asserted mid-frame SHALL take effect without a clock edge; after release, lock SHALL require a fresh SEARCH/ALIGN sequence.

Structure
REQ-035 Default timing constants and the FSM state enum SHALL reside in vga_pkg.
REQ-036 Input registering and rising-edge detection for hs/vs SHALL be a sub-module vga_edge_det.

Verification
REQ-037 Reset release, then stream from vga_timing at the defaults -> locked = 1 after the 3rd vs edge; sync_err never asserted.
REQ-038 Locked, input pixel (0,0) rgb = 12'hF00 -> 2 cycles later hcount = 0, vcount = 0, de = 1, rgb_out = 12'hF00, frame_start = 1.
REQ-039 Locked, one hs edge delayed by 3 clocks -> sync_err pulses once, locked = 0, hcount reloads to 840 at the late edge, relock after 2 clean frames.
REQ-040 Locked, hs held low -> sync_err at hcount = 840 of the next line, locked = 0.
REQ-041 Locked, pixel (850,10) rgb = 12'hABC -> de = 0, rgb_out = 0.
REQ-042 rst low at vcount = 300 -> all outputs 0 immediately; after release, locked stays 0 until the SEARCH/ALIGN sequence completes.
